// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions one raw mechanical push-button into clean, single-cycle event
// pulses for downstream counter logic. The asynchronous pin is brought into
// the clk domain with a two-flop synchroniser. It is then debounced with a
// mismatch counter. Press, release and auto-repeat events are generated by a
// small FSM.
//
// "repeat" and "release" are SystemVerilog keywords, so those two event ports
// are named repeat_pulse and release_pulse.
//
// Parameters
//   DEBOUNCE_CYCLES       consecutive mismatch cycles before level_out flips (>= 2)
//   REPEAT_EN             1: auto-repeat enabled, 0: repeat_pulse never asserts
//   REPEAT_DELAY_CYCLES   cycles from the press pulse to the first repeat (>= 2)
//   REPEAT_PERIOD_CYCLES  cycles between successive repeat pulses (>= 2)
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset (clears every flop)
//   button_in      in   raw pin, asynchronous, active-high, may bounce
//   level_out      out  debounced button level
//   push           out  1-cycle pulse on each debounced press and each auto-repeat
//   repeat_pulse   out  1-cycle pulse, together with push, for auto-repeat only
//   release_pulse  out  1-cycle pulse on each debounced release
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES      = 50000,
  parameter bit REPEAT_EN            = 1'b1,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic level_out,
  output logic push,
  output logic repeat_pulse,
  output logic release_pulse
);

  localparam int DCW  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RCW  = (RMAX > 2) ? $clog2(RMAX) : 1;

  localparam logic [DCW-1:0] DB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] DLY_LAST = RCW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RCW-1:0] PER_LAST = RCW'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } state_t;

  logic           button_r;
  logic           button_rr;
  logic [DCW-1:0] db_cnt;
  logic           mismatch;
  logic           db_done;
  logic           rise;
  logic           fall;
  state_t         state;
  logic [RCW-1:0] rcnt;

  // ---- Stage: two-flop synchroniser; only button_rr is used downstream ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      button_r  <= 1'b0;
      button_rr <= 1'b0;
    end else begin
      button_r  <= button_in;
      button_rr <= button_r;
    end
  end

  // ---- Stage: debounce -----------------------------------------------------
  // The counter tracks how many consecutive cycles the synchronised pin has
  // disagreed with the debounced level. Any agreement restarts the count, so
  // a glitch shorter than DEBOUNCE_CYCLES never reaches level_out.
  assign mismatch = (button_rr != level_out);
  assign db_done  = mismatch && (db_cnt == DB_LAST);

  // Edge events are decoded from the flip about to happen. This lets the FSM
  // register push/release on the same edge at which level_out changes.
  assign rise = db_done && !level_out;
  assign fall = db_done &&  level_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt    <= '0;
      level_out <= 1'b0;
    end else if (!mismatch) begin
      db_cnt    <= '0;
    end else if (db_done) begin
      db_cnt    <= '0;
      level_out <= ~level_out;
    end else begin
      db_cnt    <= db_cnt + 1'b1;
    end
  end

  // ---- Stage: event FSM with registered pulse outputs -----------------------
  // Pulses default low every cycle, so none can last longer than one cycle.
  // In HELD and REPEATING the release check is tested first. A release that
  // lands on a repeat terminal count therefore suppresses that repeat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rcnt          <= '0;
      push          <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      push          <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          rcnt <= '0;
          if (rise) begin
            state <= HELD;
            push  <= 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            rcnt          <= '0;
          end else if (!REPEAT_EN) begin
            rcnt <= '0;
          end else if (rcnt == DLY_LAST) begin
            state        <= REPEATING;
            push         <= 1'b1;
            repeat_pulse <= 1'b1;
            rcnt         <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        REPEATING: begin
          if (fall) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            rcnt          <= '0;
          end else if (rcnt == PER_LAST) begin
            push         <= 1'b1;
            repeat_pulse <= 1'b1;
            rcnt         <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          rcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic button_in;
  logic button2;

  logic level1, push1, rep1, rel1;
  logic level2, push2, rep2, rel2;
  logic [3:0] o1;

  int checks = 0;
  int errors = 0;
  int viol = 0;
  logic pp, pr, prl;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1),
    .REPEAT_DELAY_CYCLES(10), .REPEAT_PERIOD_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .button_in(button_in),
    .level_out(level1), .push(push1),
    .repeat_pulse(rep1), .release_pulse(rel1)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0),
    .REPEAT_DELAY_CYCLES(10), .REPEAT_PERIOD_CYCLES(3)
  ) dut_norep (
    .clk(clk), .reset(reset), .button_in(button2),
    .level_out(level2), .push(push2),
    .repeat_pulse(rep2), .release_pulse(rel2)
  );

  assign o1 = {level1, push1, rep1, rel1};

  // Pulse-shape guarantees on the repeat-enabled instance.
  always @(negedge clk) begin
    if (reset) begin
      pp  <= 1'b0;
      pr  <= 1'b0;
      prl <= 1'b0;
    end else begin
      viol <= viol + (((push1 && rel1) || (pp && push1) || (pr && rep1) ||
                       (prl && rel1)) ? 1 : 0);
      pp  <= push1;
      pr  <= rep1;
      prl <= rel1;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected word is {level_out, push, repeat, release}.
  typedef struct packed {
    logic       b;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int np, nr, nrl;
    vec_t v;

    // Table part A (index 0..31): clean press at edge 0, repeats, then a
    // release sampled at edge 22 whose completion at 27 lands on a repeat
    // terminal count (24 + 3), which must be suppressed.
    for (int i = 0; i < 32; i++) begin
      v.b   = (i <= 21);
      v.exp = {(i >= 5 && i <= 26),
               (i == 5 || i == 15 || i == 18 || i == 21 || i == 24),
               (i == 15 || i == 18 || i == 21 || i == 24),
               (i == 27)};
      vecs.push_back(v);
    end
    // Table part B (k = 0..20): high 3, low 2, then high; final rise sampled
    // at k=5, push at k=10; release sampled at k=12, pulse at k=17.
    for (int k = 0; k < 21; k++) begin
      v.b   = (k < 3) || (k >= 5 && k < 12);
      v.exp = {(k >= 10 && k <= 16), (k == 10), 1'b0, (k == 17)};
      vecs.push_back(v);
    end

    reset     = 1'b1;
    button_in = 1'b0;
    button2   = 1'b0;
    #12;
    check("reset_outputs", {28'd0, o1}, 32'd0);
    check("reset_outputs_norep", {28'd0, level2, push2, rep2, rel2}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      button_in = vecs[i].b;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {28'd0, o1}, {28'd0, vecs[i].exp});
    end

    // Press, reach REPEATING, then reset asynchronously mid-hold.
    button_in = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_press_e%0d", k), {28'd0, o1},
            (k < 5) ? 32'h0 : 32'hC);
    end
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_rep_e%0d", j), {28'd0, o1},
            (j < 10) ? 32'h8 : 32'hE);
    end
    #1 reset = 1'b1;
    #1;
    check("async_reset_drop", {28'd0, o1}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("repress_e%0d", k), {28'd0, o1},
            (k < 5) ? 32'h0 : 32'hC);
    end
    button_in = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rel_after_rst_e%0d", k), {28'd0, o1},
            (k < 5) ? 32'h8 : ((k == 5) ? 32'h1 : 32'h0));
    end

    // Repeat disabled: 50-cycle hold gives exactly one push and one release.
    np = 0; nr = 0; nrl = 0;
    button2 = 1'b1;
    for (int k = 0; k < 70; k++) begin
      if (k == 50) button2 = 1'b0;
      @(posedge clk);
      #1;
      np  += int'(push2);
      nr  += int'(rep2);
      nrl += int'(rel2);
      if (k == 30) check("norep_level_held", {31'd0, level2}, 32'd1);
    end
    check("norep_push_count", np, 1);
    check("norep_repeat_count", nr, 0);
    check("norep_release_count", nrl, 1);
    check("norep_level_final", {31'd0, level2}, 32'd0);

    check("pulse_shape_violations", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
